// File: rtl/naxi_pkg.sv
// Shared Naxi command encodings and the command record queued by the SRAM slave.
package naxi_pkg;

  localparam int unsigned NX_ADDR_W = 31;
  localparam int unsigned NX_ATTR_W = 3;
  localparam int unsigned NX_SIZE_W = 8;
  localparam int unsigned NX_ID_W   = 4;
  localparam int unsigned NX_TYPE_W = 3;

  localparam logic [NX_TYPE_W-1:0] NAXI_RD         = 3'b000;
  localparam logic [NX_TYPE_W-1:0] NAXI_WR         = 3'b001;
  localparam logic [NX_ATTR_W-1:0] NAXI_ATTR_WRACK = 3'b111;

  typedef struct packed {
    logic [NX_ADDR_W-1:0] addr;
    logic [NX_ATTR_W-1:0] attr;
    logic [NX_SIZE_W-1:0] size;
    logic [NX_ID_W-1:0]   id;
    logic [NX_TYPE_W-1:0] ctype;
  } naxi_cmd_t;

endpackage

// File: rtl/naxi_cmd_fifo.sv
// Synchronous command FIFO; a push is taken while full only when a pop frees a slot.
module naxi_cmd_fifo
  import naxi_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  naxi_cmd_t wdata_i,
  input  logic      pop_i,
  output naxi_cmd_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  naxi_cmd_t       mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/naxi_sram_slave.sv
// Naxi slave endpoint servicing queued read/write bursts from a local SRAM.
// Optional NAXI_SLV_WRACK_EN: return one acknowledge beat on rreq after each write burst.
module naxi_sram_slave
  import naxi_pkg::*;
#(
  parameter int unsigned NXADDRWIDTH = NX_ADDR_W,
  parameter int unsigned NXDATAWIDTH = 256,
  parameter int unsigned NXIDWIDTH   = NX_ID_W,
  parameter int unsigned NXTYPEWIDTH = NX_TYPE_W,
  parameter int unsigned NXSIZEWIDTH = NX_SIZE_W,
  parameter int unsigned NXATTRWIDTH = NX_ATTR_W,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned CMD_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NXADDRWIDTH-1:0] creqAddr,
  input  logic [NXATTRWIDTH-1:0] creqAttr,
  input  logic [NXSIZEWIDTH-1:0] creqSize,
  input  logic [NXIDWIDTH-1:0]   creqId,
  input  logic [NXTYPEWIDTH-1:0] creqType,
  input  logic                   creqValid,
  output logic                   creqRdStall,
  output logic                   creqWrStall,
  input  logic [NXDATAWIDTH-1:0] dreqData,
  input  logic [NXATTRWIDTH-1:0] dreqAttr,
  input  logic [NXIDWIDTH-1:0]   dreqId,
  input  logic                   dreqValid,
  output logic                   dreqStall,
  output logic [NXDATAWIDTH-1:0] rreqData,
  output logic [NXATTRWIDTH-1:0] rreqAttr,
  output logic [NXIDWIDTH-1:0]   rreqId,
  output logic                   rreqValid,
  input  logic                   rreqStall
);

  localparam int unsigned ByteOffW = $clog2(NXDATAWIDTH / 8);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);

  typedef logic [IdxW-1:0]        idx_t;
  typedef logic [NXSIZEWIDTH-1:0] cnt_t;

`ifdef NAXI_SLV_WRACK_EN
  typedef enum logic [1:0] {StIdle, StRd, StWr, StWack} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;
`endif

  state_e                 state_q, state_d;
  idx_t                   idx_q, idx_d, rd_idx, head_idx;
  cnt_t                   cnt_q, cnt_d;
  logic                   rvalid_q, rvalid_d;
  logic [NXDATAWIDTH-1:0] rdata_q;
  logic [NXIDWIDTH-1:0]   rid_q, rid_d;
  logic [NXATTRWIDTH-1:0] rattr_q, rattr_d;
  logic                   mem_re, mem_we, rdata_clr;
  logic                   fifo_full, fifo_empty, fifo_push, dispatch, rd_xfer, wr_xfer;
  naxi_cmd_t              cmd_in, head;
  logic                   unused_bits;

  logic [NXDATAWIDTH-1:0] mem [MEM_DEPTH];

  assign cmd_in = '{addr: creqAddr, attr: creqAttr, size: creqSize, id: creqId, ctype: creqType};
  assign fifo_push = creqValid && !rst && !fifo_full;

  naxi_cmd_fifo #(
    .Depth (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (cmd_in),
    .pop_i   (dispatch),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_idx    = head.addr[ByteOffW +: IdxW];
  assign unused_bits = ^{dreqAttr, dreqId, head.addr};

  assign creqRdStall = rst || fifo_full;
  assign creqWrStall = rst || fifo_full;
  assign dreqStall   = rst || (state_q != StWr);

  assign rd_xfer = (state_q == StRd) && rvalid_q && !rreqStall && !rst;
  assign wr_xfer = (state_q == StWr) && dreqValid && !rst;
  // The next command pops on the edge the last read beat leaves, keeping bursts gap-free.
  assign dispatch = !fifo_empty && !rst &&
                    ((state_q == StIdle) || (rd_xfer && (cnt_q == '0)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rattr_d   = rattr_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    rdata_clr = 1'b0;
    rd_idx    = idx_q;
    unique case (state_q)
      StIdle: begin
        rvalid_d = 1'b0;
      end
      StRd: begin
        if (rd_xfer) begin
          if (cnt_q != '0) begin
            idx_d  = idx_q + idx_t'(1);
            cnt_d  = cnt_q - cnt_t'(1);
            rd_idx = idx_q + idx_t'(1);
            mem_re = 1'b1;
          end else begin
            state_d  = StIdle;
            rvalid_d = 1'b0;
          end
        end
      end
      StWr: begin
        if (wr_xfer) begin
          mem_we = 1'b1;
          idx_d  = idx_q + idx_t'(1);
          cnt_d  = cnt_q - cnt_t'(1);
          if (cnt_q == '0) begin
`ifdef NAXI_SLV_WRACK_EN
            state_d   = StWack;
            rvalid_d  = 1'b1;
            rattr_d   = NAXI_ATTR_WRACK;
            rdata_clr = 1'b1;
`else
            state_d = StIdle;
`endif
          end
        end
      end
`ifdef NAXI_SLV_WRACK_EN
      StWack: begin
        if (!rreqStall) begin
          state_d  = StIdle;
          rvalid_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d  = StIdle;
        rvalid_d = 1'b0;
      end
    endcase

    if (dispatch) begin
      idx_d   = head_idx;
      cnt_d   = head.size;
      rid_d   = head.id;
      rattr_d = head.attr;
      if (head.ctype == NAXI_RD) begin
        state_d  = StRd;
        rvalid_d = 1'b1;
        rd_idx   = head_idx;
        mem_re   = 1'b1;
      end else if (head.ctype == NAXI_WR) begin
        state_d = StWr;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rattr_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rattr_q  <= rattr_d;
      if (mem_re) rdata_q <= mem[rd_idx];
      else if (rdata_clr) rdata_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= dreqData;
  end

  assign rreqValid = rvalid_q;
  assign rreqData  = rdata_q;
  assign rreqId    = rid_q;
  assign rreqAttr  = rattr_q;

endmodule

// File: tb/tb_naxi_sram_slave.sv
// Directed self-checking bench for naxi_sram_slave; covers NAXI_SLV_WRACK_EN when defined.
module tb_naxi_sram_slave;

  localparam int unsigned AW = 31;
  localparam int unsigned DW = 256;
  localparam int unsigned IW = 4;
  localparam int unsigned TW = 3;
  localparam int unsigned SW = 8;
  localparam int unsigned ATW = 3;
  localparam int Bound = 20;
  localparam logic [TW-1:0] TRD = 3'b000;
  localparam logic [TW-1:0] TWR = 3'b001;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  creqAddr;
  logic [ATW-1:0] creqAttr;
  logic [SW-1:0]  creqSize;
  logic [IW-1:0]  creqId;
  logic [TW-1:0]  creqType;
  logic           creqValid;
  logic           creqRdStall, creqWrStall;
  logic [DW-1:0]  dreqData;
  logic [ATW-1:0] dreqAttr;
  logic [IW-1:0]  dreqId;
  logic           dreqValid;
  logic           dreqStall;
  logic [DW-1:0]  rreqData;
  logic [ATW-1:0] rreqAttr;
  logic [IW-1:0]  rreqId;
  logic           rreqValid;
  logic           rreqStall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  naxi_sram_slave dut (
    .clk         (clk),
    .rst         (rst),
    .creqAddr    (creqAddr),
    .creqAttr    (creqAttr),
    .creqSize    (creqSize),
    .creqId      (creqId),
    .creqType    (creqType),
    .creqValid   (creqValid),
    .creqRdStall (creqRdStall),
    .creqWrStall (creqWrStall),
    .dreqData    (dreqData),
    .dreqAttr    (dreqAttr),
    .dreqId      (dreqId),
    .dreqValid   (dreqValid),
    .dreqStall   (dreqStall),
    .rreqData    (rreqData),
    .rreqAttr    (rreqAttr),
    .rreqId      (rreqId),
    .rreqValid   (rreqValid),
    .rreqStall   (rreqStall)
  );

  function automatic logic [DW-1:0] pat(input int unsigned k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + k;
    return {8{w}};
  endfunction

  task automatic send_cmd(input logic [AW-1:0] a, input logic [SW-1:0] s,
                          input logic [IW-1:0] id, input logic [TW-1:0] t,
                          input logic [ATW-1:0] at);
    int n = 0;
    creqAddr = a; creqSize = s; creqId = id; creqType = t; creqAttr = at; creqValid = 1'b1;
    while (creqRdStall && n < Bound) begin @(negedge clk); n++; end
    checks++;
    if (creqRdStall) begin
      errors++;
      $display("FAIL cmd_accept: stall=%0b after %0d cycles, required 0", creqRdStall, n);
    end
    @(negedge clk);
    creqValid = 1'b0;
  endtask

  task automatic send_wbeat(input logic [DW-1:0] d);
    int n = 0;
    dreqData = d; dreqValid = 1'b1;
    while (dreqStall && n < Bound) begin @(negedge clk); n++; end
    checks++;
    if (dreqStall) begin
      errors++;
      $display("FAIL wbeat_accept: dreqStall=%0b after %0d cycles, required 0", dreqStall, n);
    end
    @(negedge clk);
    dreqValid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rreqValid && n < Bound) begin @(negedge clk); n++; end
    checks++;
    if (!rreqValid) begin
      errors++;
      $display("FAIL rvalid_timeout: rreqValid=%0b after %0d cycles, required 1", rreqValid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({rreqValid, rreqId, rreqAttr} !== '0 || rreqData !== '0) begin
      errors++;
      $display("FAIL reset_rreq: valid=%0b id=%0h attr=%0h data=%h, required all 0",
               rreqValid, rreqId, rreqAttr, rreqData);
    end
    checks++;
    if ({creqRdStall, creqWrStall, dreqStall} !== 3'b111) begin
      errors++;
      $display("FAIL reset_stalls: got %b, required 111", {creqRdStall, creqWrStall, dreqStall});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({creqRdStall, creqWrStall, dreqStall} !== 3'b001) begin
      errors++;
      $display("FAIL idle_stalls: got %b, required 001", {creqRdStall, creqWrStall, dreqStall});
    end
  endtask

  task automatic test_write_read();
    send_cmd(31'h40, 8'd3, 4'd5, TWR, 3'd1);
    for (int i = 0; i < 4; i++) send_wbeat(pat(i));
    send_cmd(31'h40, 8'd3, 4'd5, TRD, 3'd4);
    checks++;
    if (rreqValid !== 1'b0) begin
      errors++; $display("FAIL rd_latency_early: rreqValid=%0b, required 0", rreqValid);
    end
    @(negedge clk);
    checks++;
    if (rreqValid !== 1'b1) begin
      errors++; $display("FAIL rd_latency: rreqValid=%0b, required 1", rreqValid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rreqValid !== 1'b1 || rreqData !== pat(i) || rreqId !== 4'd5 || rreqAttr !== 3'd4) begin
        errors++;
        $display("FAIL rd_beat%0d: v=%0b id=%0h attr=%0h data=%h, required v=1 id=5 attr=4 data=%h",
                 i, rreqValid, rreqId, rreqAttr, rreqData, pat(i));
      end
      @(negedge clk);
    end
    checks++;
    if (rreqValid !== 1'b0) begin
      errors++; $display("FAIL rd_end: rreqValid=%0b, required 0", rreqValid);
    end
  endtask

  task automatic test_stall_hold();
    send_cmd(31'h40, 8'd3, 4'd5, TRD, 3'd4);
    wait_valid();
    checks++;
    if (rreqData !== pat(0)) begin
      errors++; $display("FAIL stall_beat0: data=%h, required %h", rreqData, pat(0));
    end
    @(negedge clk);
    rreqStall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rreqValid !== 1'b1 || rreqData !== pat(1) || rreqId !== 4'd5 || rreqAttr !== 3'd4) begin
        errors++;
        $display("FAIL stall_hold%0d: v=%0b id=%0h attr=%0h data=%h, required v=1 id=5 attr=4 data=%h",
                 k, rreqValid, rreqId, rreqAttr, rreqData, pat(1));
      end
      if (k < 3) @(negedge clk);
    end
    rreqStall = 1'b0;
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rreqValid !== 1'b1 || rreqData !== pat(i)) begin
        errors++;
        $display("FAIL stall_after%0d: v=%0b data=%h, required v=1 data=%h",
                 i, rreqValid, rreqData, pat(i));
      end
    end
    @(negedge clk);
    checks++;
    if (rreqValid !== 1'b0) begin
      errors++; $display("FAIL stall_end: rreqValid=%0b, required 0", rreqValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [3];
    logic [IW-1:0] exp_id [3];
    exp_d = '{pat(0), pat(1), pat(2)};
    exp_id = '{4'd1, 4'd1, 4'd2};
    rreqStall = 1'b1;
    send_cmd(31'h40, 8'd1, 4'd1, TRD, 3'd0);
    send_cmd(31'h80, 8'd0, 4'd2, TRD, 3'd0);
    wait_valid();
    rreqStall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rreqValid !== 1'b1 || rreqData !== exp_d[i] || rreqId !== exp_id[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: v=%0b id=%0h data=%h, required v=1 id=%0h data=%h",
                 i, rreqValid, rreqId, rreqData, exp_id[i], exp_d[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (rreqValid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: rreqValid=%0b, required 0", rreqValid);
    end
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    int beats;
    rreqStall = 1'b1;
    creqAddr = 31'h40; creqSize = 8'd0; creqId = 4'd3; creqType = TRD; creqAttr = 3'd0;
    creqValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!creqRdStall) acc++;
      @(negedge clk);
    end
    creqValid = 1'b0;
    checks++;
    if (acc !== 5 || creqRdStall !== 1'b1 || creqWrStall !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full: accepts=%0d rdStall=%0b wrStall=%0b, required 5 1 1",
               acc, creqRdStall, creqWrStall);
    end
    beats = rreqValid ? 1 : 0;
    rreqStall = 1'b0;
    @(negedge clk);
    checks++;
    if (creqRdStall !== 1'b0) begin
      errors++; $display("FAIL fifo_release: creqRdStall=%0b, required 0", creqRdStall);
    end
    for (int i = 0; i < 12; i++) begin
      if (rreqValid) begin
        beats++;
        checks++;
        if (rreqData !== pat(0)) begin
          errors++; $display("FAIL fifo_drain_data: data=%h, required %h", rreqData, pat(0));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (beats !== 5) begin
      errors++; $display("FAIL fifo_drain_count: beats=%0d, required 5", beats);
    end
  endtask

  task automatic test_wrap();
    send_cmd(31'h7FC0, 8'd3, 4'd6, TWR, 3'd0);
    for (int i = 0; i < 4; i++) send_wbeat(pat(16 + i));
    send_cmd(31'h0, 8'd1, 4'd6, TRD, 3'd0);
    wait_valid();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rreqValid !== 1'b1 || rreqData !== pat(18 + i)) begin
        errors++;
        $display("FAIL wrap_low%0d: v=%0b data=%h, required v=1 data=%h",
                 i, rreqValid, rreqData, pat(18 + i));
      end
      @(negedge clk);
    end
    send_cmd(31'h7FE0, 8'd0, 4'd6, TRD, 3'd0);
    wait_valid();
    checks++;
    if (rreqData !== pat(17)) begin
      errors++; $display("FAIL wrap_top: data=%h, required %h", rreqData, pat(17));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    rreqStall = 1'b1;
    send_cmd(31'h40, 8'd3, 4'd4, TRD, 3'd1);
    send_cmd(31'h40, 8'd0, 4'd5, TRD, 3'd1);
    wait_valid();
    rreqStall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rreqValid !== 1'b1 || rreqData !== pat(2)) begin
      errors++;
      $display("FAIL rstmid_beat2: v=%0b data=%h, required v=1 data=%h", rreqValid, rreqData, pat(2));
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rreqValid !== 1'b0 || creqRdStall !== 1'b1 || dreqStall !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state: v=%0b rdStall=%0b dStall=%0b, required 0 1 1",
               rreqValid, creqRdStall, dreqStall);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rreqValid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL rstmid_fifo_empty: stray beats=%0d, required 0", stray);
    end
    send_cmd(31'h60, 8'd0, 4'd7, TRD, 3'd2);
    wait_valid();
    checks++;
    if (rreqData !== pat(1) || rreqId !== 4'd7 || rreqAttr !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_after: id=%0h attr=%0h data=%h, required id=7 attr=2 data=%h",
               rreqId, rreqAttr, rreqData, pat(1));
    end
    @(negedge clk);
  endtask

  task automatic test_wrack_and_drop();
    int stray = 0;
    send_cmd(31'h140, 8'd0, 4'd11, 3'b101, 3'd0);
    for (int i = 0; i < 6; i++) begin
      if (rreqValid) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL drop_unknown: beats=%0d, required 0", stray);
    end
    send_cmd(31'h140, 8'd0, 4'd9, TWR, 3'd2);
    send_wbeat(pat(32));
`ifdef NAXI_SLV_WRACK_EN
    checks++;
    if (rreqValid !== 1'b1 || rreqId !== 4'd9 || rreqAttr !== 3'b111 || rreqData !== '0) begin
      errors++;
      $display("FAIL wrack_beat: v=%0b id=%0h attr=%0h data=%h, required v=1 id=9 attr=7 data=0",
               rreqValid, rreqId, rreqAttr, rreqData);
    end
    @(negedge clk);
    checks++;
    if (rreqValid !== 1'b0) begin
      errors++; $display("FAIL wrack_end: rreqValid=%0b, required 0", rreqValid);
    end
`else
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (rreqValid) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL no_wrack: beats=%0d, required 0", stray);
    end
`endif
    send_cmd(31'h140, 8'd0, 4'd12, TRD, 3'd0);
    wait_valid();
    checks++;
    if (rreqData !== pat(32) || rreqId !== 4'd12) begin
      errors++;
      $display("FAIL wr_readback: id=%0h data=%h, required id=c data=%h", rreqId, rreqData, pat(32));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    creqAddr = '0; creqAttr = '0; creqSize = '0; creqId = '0; creqType = '0; creqValid = 1'b0;
    dreqData = '0; dreqAttr = '0; dreqId = '0; dreqValid = 1'b0;
    rreqStall = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_stall_hold();
    test_back_to_back();
    test_fifo_full();
    test_wrap();
    test_reset_mid();
    test_wrack_and_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
